// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction-memory request handshake, IR and field decode.
// Optional macro IFETCH_TIMEOUT_EN adds a wait-state watchdog and the fetchFault output.
module instr_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    OPBITS     = 4,
   parameter int                    FUNCTBITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pcEn,
   input  logic                  branch,
   input  logic                  jump,
   input  logic [7:0]            branchDisp,
   input  logic [ADDR_WIDTH-1:0] jumpTarget,
   output logic                  imemReq,
   output logic [ADDR_WIDTH-1:0] imemAddr,
   input  logic                  imemReady,
   input  logic [15:0]           imemData,
   output logic                  instrValid,
   output logic [OPBITS-1:0]     opcode,
   output logic [3:0]            rdest,
   output logic [FUNCTBITS-1:0]  functionCode,
   output logic [3:0]            rsrc,
   output logic [7:0]            imm8,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] linkAddr
`ifdef IFETCH_TIMEOUT_EN
   ,
   output logic                  fetchFault
`endif
);

   typedef enum logic {S_REQ, S_HOLD} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [15:0]             ir;
   logic                    load_ir;
   logic [ADDR_WIDTH-1:0]   pc_nxt;
   logic [ADDR_WIDTH-1:0]   disp_ext;

   // Handshake: imemReq is held high with imemAddr stable for every REQ cycle;
   // the word is taken on the first cycle where imemReq and imemReady are both high.
   assign imemReq    = (state == S_REQ) && !reset;
   assign instrValid = (state == S_HOLD) && !reset;
   assign imemAddr   = pc;
   assign linkAddr   = pc + ADDR_WIDTH'(1);
   assign disp_ext   = {{(ADDR_WIDTH-8){branchDisp[7]}}, branchDisp};

   assign opcode       = ir[15 -: OPBITS];
   assign rdest        = ir[11:8];
   assign functionCode = ir[7 -: FUNCTBITS];
   assign rsrc         = ir[3:0];
   assign imm8         = ir[7:0];

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      load_ir   = 1'b0;
      case (state)
         S_REQ: begin
            if (imemReady) begin
               load_ir   = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (pcEn) begin
               state_nxt = S_REQ;
               if (jump)
                  pc_nxt = jumpTarget;
               else if (branch)
                  pc_nxt = pc + ADDR_WIDTH'(1) + disp_ext;
               else
                  pc_nxt = pc + ADDR_WIDTH'(1);
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_REQ;
         pc    <= RESET_PC;
         ir    <= 16'h0000;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (load_ir)
            ir <= imemData;
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   logic [3:0] wait_cnt;
   logic       fault_hit;

   // The 15th consecutive wait cycle raises the fault and restarts the count.
   assign fault_hit  = (state == S_REQ) && !imemReady && (wait_cnt == 4'd14);
   assign fetchFault = fault_hit && !reset;

   always_ff @(posedge clk) begin
      if (reset || state != S_REQ || imemReady)
         wait_cnt <= 4'd0;
      else if (fault_hit)
         wait_cnt <= 4'd0;
      else
         wait_cnt <= wait_cnt + 4'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// fetch/retire stream checked against a PC/IR reference model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcEn;
   logic        branch;
   logic        jump;
   logic [7:0]  branchDisp;
   logic [15:0] jumpTarget;
   logic        imemReq;
   logic [15:0] imemAddr;
   logic        imemReady;
   logic [15:0] imemData;
   logic        instrValid;
   logic [3:0]  opcode;
   logic [3:0]  rdest;
   logic [3:0]  functionCode;
   logic [3:0]  rsrc;
   logic [7:0]  imm8;
   logic [15:0] pc;
   logic [15:0] linkAddr;
`ifdef IFETCH_TIMEOUT_EN
   logic        fetchFault;
`endif

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   instr_fetch dut (
      .clk(clk), .reset(reset), .pcEn(pcEn), .branch(branch), .jump(jump),
      .branchDisp(branchDisp), .jumpTarget(jumpTarget),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
      .instrValid(instrValid), .opcode(opcode), .rdest(rdest),
      .functionCode(functionCode), .rsrc(rsrc), .imm8(imm8),
      .pc(pc), .linkAddr(linkAddr)
`ifdef IFETCH_TIMEOUT_EN
      , .fetchFault(fetchFault)
`endif
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; pcEn = 1'b0; branch = 1'b0; jump = 1'b0; imemReady = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
   endtask

   task automatic do_fetch(input logic [15:0] data, input int waits);
      imemReady = 1'b0;
      repeat (waits) cyc();
      imemReady = 1'b1;
      imemData  = data;
      cyc();
      imemReady = 1'b0;
      imemData  = 16'($urandom);
   endtask

   task automatic do_retire(input logic br, input logic jp, input logic [7:0] disp,
                            input logic [15:0] tgt);
      pcEn = 1'b1; branch = br; jump = jp; branchDisp = disp; jumpTarget = tgt;
      cyc();
      pcEn = 1'b0; branch = 1'b0; jump = 1'b0;
   endtask

   // from REQ, land in HOLD at address a holding word data
   task automatic goto_hold(input logic [15:0] a, input logic [15:0] data);
      do_fetch(16'h0000, 0);
      do_retire(1'b0, 1'b1, 8'h00, a);
      do_fetch(data, 0);
   endtask

   // tests
   task automatic test_reset();
      reset = 1'b1; pcEn = 1'b0; branch = 1'b0; jump = 1'b0;
      imemReady = 1'b1; imemData = 16'hFFFF; branchDisp = 8'h00; jumpTarget = 16'h0000;
      cyc();
      cyc();
      total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
      total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instrValid); end
      total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imemReq); end
      total++; if ({opcode, rdest, functionCode, rsrc} !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", {opcode, rdest, functionCode, rsrc}); end
      reset = 1'b0; imemData = 16'h5123;
      #1;
      total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imemReq); end
      total++; if (imemAddr !== 16'h0000) begin bad++; $display("FAIL first_addr got=%h exp=0000", imemAddr); end
      cyc();
      imemReady = 1'b0;
      total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", instrValid); end
      total++; if (opcode !== 4'h5) begin bad++; $display("FAIL first_opcode got=%h exp=5", opcode); end
      total++; if (rdest !== 4'h1) begin bad++; $display("FAIL first_rdest got=%h exp=1", rdest); end
      total++; if (functionCode !== 4'h2) begin bad++; $display("FAIL first_funct got=%h exp=2", functionCode); end
      total++; if (rsrc !== 4'h3) begin bad++; $display("FAIL first_rsrc got=%h exp=3", rsrc); end
      total++; if (imm8 !== 8'h23) begin bad++; $display("FAIL first_imm8 got=%h exp=23", imm8); end
      total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imemReq); end
   endtask

   task automatic test_sequential();
      apply_reset();
      goto_hold(16'h0010, 16'hA5C3);
      total++; if (pc !== 16'h0010) begin bad++; $display("FAIL seq_start_pc got=%h exp=0010", pc); end
      total++; if (linkAddr !== 16'h0011) begin bad++; $display("FAIL seq_link0 got=%h exp=0011", linkAddr); end
      do_retire(1'b0, 1'b0, 8'h00, 16'h0000);
      total++; if (pc !== 16'h0011) begin bad++; $display("FAIL seq_pc got=%h exp=0011", pc); end
      total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL seq_valid got=%b exp=0", instrValid); end
      total++; if (imemAddr !== 16'h0011) begin bad++; $display("FAIL seq_addr got=%h exp=0011", imemAddr); end
      total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL seq_req got=%b exp=1", imemReq); end
      total++; if (linkAddr !== 16'h0012) begin bad++; $display("FAIL seq_link1 got=%h exp=0012", linkAddr); end
   endtask

   task automatic test_branch();
      apply_reset();
      goto_hold(16'h0020, 16'h1111);
      do_retire(1'b1, 1'b0, 8'hFC, 16'h0000);
      total++; if (pc !== 16'h001D) begin bad++; $display("FAIL br_back got=%h exp=001d", pc); end
      goto_hold(16'hFFFF, 16'h2222);
      total++; if (linkAddr !== 16'h0000) begin bad++; $display("FAIL link_wrap got=%h exp=0000", linkAddr); end
      do_retire(1'b1, 1'b0, 8'h01, 16'h0000);
      total++; if (pc !== 16'h0001) begin bad++; $display("FAIL br_wrap got=%h exp=0001", pc); end
      goto_hold(16'hFFFF, 16'h3333);
      do_retire(1'b0, 1'b0, 8'h00, 16'h0000);
      total++; if (pc !== 16'h0000) begin bad++; $display("FAIL seq_wrap got=%h exp=0000", pc); end
      goto_hold(16'h0002, 16'h4444);
      do_retire(1'b1, 1'b0, 8'h80, 16'h0000);
      total++; if (pc !== 16'hFF83) begin bad++; $display("FAIL br_neg_wrap got=%h exp=ff83", pc); end
   endtask

   task automatic test_priority();
      apply_reset();
      goto_hold(16'h0100, 16'h7E42);
      do_retire(1'b1, 1'b1, 8'h05, 16'h1234);
      total++; if (pc !== 16'h1234) begin bad++; $display("FAIL jump_prio got=%h exp=1234", pc); end
      do_fetch(16'h3C5A, 1);
      branch = 1'b1; jump = 1'b1; jumpTarget = 16'hBEEF; imemReady = 1'b1; imemData = 16'hFFFF;
      cyc();
      cyc();
      branch = 1'b0; jump = 1'b0; imemReady = 1'b0;
      total++; if (pc !== 16'h1234) begin bad++; $display("FAIL no_pcen_pc got=%h exp=1234", pc); end
      total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL no_pcen_valid got=%b exp=1", instrValid); end
      total++; if ({opcode, imm8} !== 12'h35A) begin bad++; $display("FAIL hold_ir_stable got=%h exp=35a", {opcode, imm8}); end
      do_retire(1'b0, 1'b0, 8'h00, 16'h0000);
      pcEn = 1'b1; jump = 1'b1; jumpTarget = 16'h4444;
      cyc();
      pcEn = 1'b0; jump = 1'b0;
      total++; if (pc !== 16'h1235) begin bad++; $display("FAIL req_pcen_pc got=%h exp=1235", pc); end
      total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL req_pcen_req got=%b exp=1", imemReq); end
   endtask

   task automatic test_wait_reset();
      apply_reset();
      goto_hold(16'h0040, 16'h5555);
      do_retire(1'b0, 1'b0, 8'h00, 16'h0000);
      imemReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if (imemAddr !== 16'h0041 || instrValid !== 1'b0) begin bad++; $display("FAIL wait_addr got=%h/%b exp=0041/0", imemAddr, instrValid); end
      end
      reset = 1'b1;
      #1;
      total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_mid_req got=%b exp=0", imemReq); end
      cyc();
      total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_mid_pc got=%h exp=0000", pc); end
      reset = 1'b0;
      #1;
      total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin bad++; $display("FAIL resume_req got=%b/%h exp=1/0000", imemReq, imemAddr); end
      do_fetch(16'h9ABC, 2);
      total++; if (instrValid !== 1'b1 || opcode !== 4'h9) begin bad++; $display("FAIL resume_fetch got=%b/%h exp=1/9", instrValid, opcode); end
      reset = 1'b1; pcEn = 1'b1; jump = 1'b1; jumpTarget = 16'h7777;
      cyc();
      reset = 1'b0; pcEn = 1'b0; jump = 1'b0;
      total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_vs_pcen got=%h exp=0000", pc); end
   endtask

`ifdef IFETCH_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      imemReady = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         total++; if (fetchFault !== (c % 15 == 0)) begin bad++; $display("FAIL timeout_pulse cycle=%0d got=%b", c, fetchFault); end
         total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin bad++; $display("FAIL timeout_req got=%b/%h exp=1/0000", imemReq, imemAddr); end
         cyc();
      end
   endtask
`endif

   task automatic test_random();
      int          m_pc;
      int          w;
      int          kind;
      int          sd;
      logic [15:0] d;
      logic [15:0] e;
      logic [15:0] tgt;
      logic [7:0]  disp;
      logic        br;
      apply_reset();
      m_pc = 0;
      for (int n = 0; n < 150; n++) begin
         w = $urandom_range(0, 3);
         d = 16'($urandom);
         exp_q.push_back(d);
         imemReady = 1'b0;
         for (int k = 0; k < w; k++) begin
            cyc();
            total++; if (imemAddr !== 16'(m_pc) || instrValid !== 1'b0) begin bad++; $display("FAIL rnd_wait got=%h/%b exp=%h/0", imemAddr, instrValid, 16'(m_pc)); end
         end
         imemReady = 1'b1;
         imemData  = d;
         cyc();
         imemReady = 1'b0;
         e = exp_q.pop_front();
         total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL rnd_valid got=%b exp=1", instrValid); end
         total++; if ({opcode, rdest, functionCode, rsrc} !== e || imm8 !== e[7:0]) begin bad++; $display("FAIL rnd_fields got=%h exp=%h", {opcode, rdest, functionCode, rsrc}, e); end
         total++; if (pc !== 16'(m_pc) || linkAddr !== 16'((m_pc + 1) % 65536)) begin bad++; $display("FAIL rnd_pc got=%h/%h exp=%h", pc, linkAddr, 16'(m_pc)); end
         repeat ($urandom_range(0, 2)) begin
            branch = 1'($urandom); jump = 1'($urandom); jumpTarget = 16'($urandom);
            imemReady = 1'($urandom);
            cyc();
         end
         branch = 1'b0; jump = 1'b0; imemReady = 1'b0;
         kind = $urandom_range(0, 2);
         disp = 8'($urandom);
         tgt  = 16'($urandom);
         br   = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
         do_retire(br, kind == 2, disp, tgt);
         if (kind == 2)
            m_pc = tgt;
         else if (kind == 1) begin
            sd   = (disp < 128) ? int'(disp) : int'(disp) - 256;
            m_pc = ((m_pc + 1 + sd) % 65536 + 65536) % 65536;
         end else
            m_pc = (m_pc + 1) % 65536;
         total++; if (pc !== 16'(m_pc) || instrValid !== 1'b0) begin bad++; $display("FAIL rnd_retire got=%h/%b exp=%h/0", pc, instrValid, 16'(m_pc)); end
      end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_priority();
      test_wait_reset();
`ifdef IFETCH_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
